rv_plic_edge_counter: RTL and testbench



---
 rtl/rv_plic_edge_counter_if.sv | 24 ++
 rtl/rv_plic_edge_counter.sv | 90 +++++++++
 tb/tb_rv_plic_edge_counter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_plic_edge_counter_if.sv
// Signal bundle between the PLIC side (master) and the edge/pulse event counter (slave).
// The master drives events, enables, acks and overflow clears; the slave returns levels and counts.
interface rv_plic_edge_counter_if #(
  parameter int NumSrc = 2,
  parameter int CntW   = 4
);
  logic [NumSrc-1:0]      en_i;
  logic [NumSrc-1:0]      src_i;
  logic [NumSrc-1:0]      ack_i;
  logic [NumSrc-1:0]      ovf_clr_i;
  logic [NumSrc-1:0]      intr_o;
  logic [NumSrc-1:0]      ovf_o;
  logic [NumSrc*CntW-1:0] cnt_o;

  modport master (
    output en_i, src_i, ack_i, ovf_clr_i,
    input  intr_o, ovf_o, cnt_o
  );

  modport slave (
    input  en_i, src_i, ack_i, ovf_clr_i,
    output intr_o, ovf_o, cnt_o
  );
endinterface

// File: rtl/rv_plic_edge_counter.sv
// Per-source saturating pending-event counter turning pulse/edge events into PLIC level requests.
// Define RV_PLIC_EDGE_CNT_DETECT_EN to treat src_i as a level and count rising edges only.
module rv_plic_edge_counter #(
  parameter int NumSrc = 2,
  parameter int CntW   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  rv_plic_edge_counter_if.slave  bus
);

  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntZero = '0;

  // Source 0 is reserved: its outputs are constant and its inputs have no effect.
  assign bus.intr_o[0]         = 1'b0;
  assign bus.ovf_o[0]          = 1'b0;
  assign bus.cnt_o[CntW-1:0]   = CntZero;

  logic unused_src0;
  assign unused_src0 = ^{bus.en_i[0], bus.src_i[0], bus.ack_i[0], bus.ovf_clr_i[0]};

  for (genvar s = 1; s < NumSrc; s++) begin : g_src
    logic            ev;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            ovf_q;
    logic            ovf_d;
    logic            at_max;
    logic            is_zero;

`ifdef RV_PLIC_EDGE_CNT_DETECT_EN
    logic prev_q;

    // History follows src_i every cycle, even while the source is disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= bus.src_i[s];
      end
    end

    assign ev = bus.src_i[s] & ~prev_q & bus.en_i[s];
`else
    assign ev = bus.src_i[s] & bus.en_i[s];
`endif

    assign at_max  = (cnt_q == CntMax);
    assign is_zero = (cnt_q == CntZero);

    always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      cnt_d = cnt_q;
      ovf_d = ovf_q & ~bus.ovf_clr_i[s];
      if (ev && !bus.ack_i[s]) begin
        if (at_max) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end else if (ev && bus.ack_i[s]) begin
        // One in, one out; an ack against an empty counter is spurious, the event survives.
        if (is_zero) begin
          cnt_d = CntOne;
        end
      end else if (bus.ack_i[s] && !is_zero) begin
        cnt_d = cnt_q - CntOne;
      end
    end

    // NOTE: the counters are a handful of flops, not a memory, so they take the async reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= CntZero;
        ovf_q <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign bus.intr_o[s]              = ~is_zero;
    assign bus.ovf_o[s]               = ovf_q;
    assign bus.cnt_o[s*CntW +: CntW]  = cnt_q;
  end

endmodule

// File: tb/tb_rv_plic_edge_counter.sv
// Self-checking bench for rv_plic_edge_counter: directed scenarios plus a randomized run
// compared against an arithmetic pending-count model.
module tb_rv_plic_edge_counter;

  localparam int NumSrc = 2;
  localparam int CntW   = 4;
  localparam int CntMax = (1 << CntW) - 1;

  logic clk_i = 1'b0;
  logic rst_ni;

  rv_plic_edge_counter_if #(.NumSrc(NumSrc), .CntW(CntW)) bus ();

  rv_plic_edge_counter #(.NumSrc(NumSrc), .CntW(CntW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  int m_cnt  [NumSrc];
  bit m_ovf  [NumSrc];
  bit m_prev [NumSrc];

  function automatic void model_reset();
    for (int s = 0; s < NumSrc; s++) begin
      m_cnt[s]  = 0;
      m_ovf[s]  = 1'b0;
      m_prev[s] = 1'b0;
    end
  endfunction

  // Pending count = old count + new event - honoured ack, clipped at the maximum.
  function automatic void model_step(input logic [NumSrc-1:0] en, input logic [NumSrc-1:0] src,
                                     input logic [NumSrc-1:0] ack, input logic [NumSrc-1:0] clr);
    for (int s = 1; s < NumSrc; s++) begin
      int n;
      int ev;
`ifdef RV_PLIC_EDGE_CNT_DETECT_EN
      ev = (src[s] && !m_prev[s] && en[s]) ? 1 : 0;
`else
      ev = (src[s] && en[s]) ? 1 : 0;
`endif
      m_prev[s] = src[s];
      n = m_cnt[s] + ev;
      if (ack[s] && m_cnt[s] > 0) n = n - 1;
      if (clr[s]) m_ovf[s] = 1'b0;
      if (n > CntMax) begin
        n = CntMax;
        m_ovf[s] = 1'b1;
      end
      m_cnt[s] = n;
    end
  endfunction

  function automatic logic [NumSrc*CntW-1:0] exp_cnt();
    logic [NumSrc*CntW-1:0] r;
    r = '0;
    for (int s = 0; s < NumSrc; s++) r[s*CntW +: CntW] = CntW'(m_cnt[s]);
    return r;
  endfunction

  function automatic logic [NumSrc-1:0] exp_intr();
    logic [NumSrc-1:0] r;
    for (int s = 0; s < NumSrc; s++) r[s] = (m_cnt[s] != 0);
    return r;
  endfunction

  function automatic logic [NumSrc-1:0] exp_ovf();
    logic [NumSrc-1:0] r;
    for (int s = 0; s < NumSrc; s++) r[s] = m_ovf[s];
    return r;
  endfunction

  // One clock: inputs applied now, sampled at the next edge, outputs settle 1 time unit later.
  task automatic step(input logic [NumSrc-1:0] en, input logic [NumSrc-1:0] src,
                      input logic [NumSrc-1:0] ack, input logic [NumSrc-1:0] clr);
    bus.en_i      = en;
    bus.src_i     = src;
    bus.ack_i     = ack;
    bus.ovf_clr_i = clr;
    @(posedge clk_i);
    model_step(en, src, ack, clr);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      step(2'b11, 2'b10, 2'b00, 2'b00);
      step(2'b11, 2'b00, 2'b00, 2'b00);
    end
  endtask

  task automatic acks(input int n);
    for (int i = 0; i < n; i++) step(2'b11, 2'b00, 2'b10, 2'b00);
  endtask

  task automatic test_reset();
    bus.en_i = '0; bus.src_i = '0; bus.ack_i = '0; bus.ovf_clr_i = '0;
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if ({bus.cnt_o, bus.ovf_o, bus.intr_o} !== '0) begin
      bad++;
      $display("FAIL reset_state: got cnt=%h ovf=%b intr=%b required all zero",
               bus.cnt_o, bus.ovf_o, bus.intr_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_single_event();
    step(2'b11, 2'b10, 2'b00, 2'b00);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== CntW'(1) || bus.intr_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL single_event: got cnt1=%0d intr1=%b required cnt1=1 intr1=1",
               bus.cnt_o[CntW +: CntW], bus.intr_o[1]);
    end
    step(2'b11, 2'b00, 2'b10, 2'b00);
    total++;
    if (bus.intr_o[1] !== 1'b0 || bus.cnt_o[CntW +: CntW] !== '0) begin
      bad++;
      $display("FAIL single_ack: got cnt1=%0d intr1=%b required cnt1=0 intr1=0",
               bus.cnt_o[CntW +: CntW], bus.intr_o[1]);
    end
  endtask

  task automatic test_saturation();
    pulse(20);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== CntW'(CntMax) || bus.ovf_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL saturate: got cnt1=%0d ovf1=%b required cnt1=%0d ovf1=1",
               bus.cnt_o[CntW +: CntW], bus.ovf_o[1], CntMax);
    end
    acks(CntMax - 1);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== CntW'(1) || bus.intr_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL drain_hold: got cnt1=%0d intr1=%b required cnt1=1 intr1=1",
               bus.cnt_o[CntW +: CntW], bus.intr_o[1]);
    end
    acks(1);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== '0 || bus.intr_o[1] !== 1'b0 || bus.ovf_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL drain_empty: got cnt1=%0d intr1=%b ovf1=%b required 0 0 1",
               bus.cnt_o[CntW +: CntW], bus.intr_o[1], bus.ovf_o[1]);
    end
    step(2'b11, 2'b00, 2'b00, 2'b10);
    total++;
    if (bus.ovf_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got ovf1=%b required 0", bus.ovf_o[1]);
    end
  endtask

  task automatic test_simultaneous();
    pulse(3);
    step(2'b11, 2'b10, 2'b10, 2'b00);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== CntW'(3)) begin
      bad++;
      $display("FAIL ev_ack_at3: got cnt1=%0d required 3", bus.cnt_o[CntW +: CntW]);
    end
    step(2'b11, 2'b00, 2'b00, 2'b00);
    acks(3);
    step(2'b11, 2'b10, 2'b10, 2'b00);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== CntW'(1) || bus.intr_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL ev_ack_at0: got cnt1=%0d intr1=%b required cnt1=1 intr1=1",
               bus.cnt_o[CntW +: CntW], bus.intr_o[1]);
    end
    step(2'b11, 2'b00, 2'b10, 2'b00);
    step(2'b11, 2'b00, 2'b10, 2'b00);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== '0 || bus.intr_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL ack_at0: got cnt1=%0d intr1=%b required cnt1=0 intr1=0",
               bus.cnt_o[CntW +: CntW], bus.intr_o[1]);
    end
    pulse(CntMax);
    step(2'b11, 2'b10, 2'b10, 2'b00);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== CntW'(CntMax) || bus.ovf_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL ev_ack_atmax: got cnt1=%0d ovf1=%b required cnt1=%0d ovf1=0",
               bus.cnt_o[CntW +: CntW], bus.ovf_o[1], CntMax);
    end
    step(2'b11, 2'b00, 2'b00, 2'b00);
    acks(CntMax);
  endtask

  task automatic test_enable();
    pulse(2);
    step(2'b01, 2'b10, 2'b00, 2'b00);
    step(2'b01, 2'b00, 2'b00, 2'b00);
    step(2'b01, 2'b10, 2'b00, 2'b00);
    step(2'b01, 2'b10, 2'b00, 2'b00);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== CntW'(2)) begin
      bad++;
      $display("FAIL disabled_hold: got cnt1=%0d required 2", bus.cnt_o[CntW +: CntW]);
    end
    step(2'b01, 2'b00, 2'b10, 2'b00);
    step(2'b01, 2'b00, 2'b10, 2'b00);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== '0 || bus.intr_o[1] !== 1'b0) begin
      bad++;
      $display("FAIL disabled_drain: got cnt1=%0d intr1=%b required 0 0",
               bus.cnt_o[CntW +: CntW], bus.intr_o[1]);
    end
  endtask

  task automatic test_src0();
    for (int i = 0; i < 10; i++) begin
      logic b;
      b = i[0];
      step(2'b11, {1'b0, ~b}, {1'b0, b}, {1'b0, b});
      total++;
      if (bus.cnt_o[CntW-1:0] !== '0 || bus.intr_o[0] !== 1'b0 || bus.ovf_o[0] !== 1'b0) begin
        bad++;
        $display("FAIL src0_tied: got cnt0=%0d intr0=%b ovf0=%b required all 0",
                 bus.cnt_o[CntW-1:0], bus.intr_o[0], bus.ovf_o[0]);
      end
    end
  endtask

  task automatic test_held_high();
    int want;
`ifdef RV_PLIC_EDGE_CNT_DETECT_EN
    want = 1;
`else
    want = 4;
`endif
    step(2'b11, 2'b00, 2'b00, 2'b00);
    repeat (4) step(2'b11, 2'b10, 2'b00, 2'b00);
    step(2'b11, 2'b00, 2'b00, 2'b00);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== CntW'(want)) begin
      bad++;
      $display("FAIL held_high: got cnt1=%0d required %0d", bus.cnt_o[CntW +: CntW], want);
    end
    acks(want);
  endtask

  task automatic test_async_reset();
    pulse(CntMax + 2);
    acks(CntMax - 5);
    total++;
    if (bus.cnt_o[CntW +: CntW] !== CntW'(5) || bus.ovf_o[1] !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: got cnt1=%0d ovf1=%b required cnt1=5 ovf1=1",
               bus.cnt_o[CntW +: CntW], bus.ovf_o[1]);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({bus.cnt_o, bus.ovf_o, bus.intr_o} !== '0) begin
      bad++;
      $display("FAIL async_reset: got cnt=%h ovf=%b intr=%b required all zero",
               bus.cnt_o, bus.ovf_o, bus.intr_o);
    end
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step(2'b11, 2'b00, 2'b00, 2'b00);
    total++;
    if ({bus.cnt_o, bus.ovf_o, bus.intr_o} !== '0) begin
      bad++;
      $display("FAIL post_reset: got cnt=%h ovf=%b intr=%b required all zero",
               bus.cnt_o, bus.ovf_o, bus.intr_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [NumSrc-1:0] en, src, ack, clr;
      en  = NumSrc'($urandom_range(0, 7) != 0 ? '1 : $urandom);
      src = NumSrc'($urandom);
      ack = NumSrc'(($urandom_range(0, 2) == 0) ? $urandom : 0);
      clr = NumSrc'(($urandom_range(0, 9) == 0) ? $urandom : 0);
      step(en, src, ack, clr);
      total++;
      if ({bus.cnt_o, bus.ovf_o, bus.intr_o} !== {exp_cnt(), exp_ovf(), exp_intr()}) begin
        bad++;
        $display("FAIL random_cycle%0d: got cnt=%h ovf=%b intr=%b required cnt=%h ovf=%b intr=%b",
                 i, bus.cnt_o, bus.ovf_o, bus.intr_o, exp_cnt(), exp_ovf(), exp_intr());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_saturation();
    test_simultaneous();
    test_enable();
    test_src0();
    test_held_high();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
